// File: rtl/multiplier_datapath_taint_track_pkg.sv
// ============================================================================
// Module : multiplier_datapath_taint_track_pkg
// Brief  : Shared types, default width and taint helper for the taint-tracked
//          shift-add multiplier (datapath and controller).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package multiplier_datapath_taint_track_pkg;

    localparam int WIDTH_DEFAULT = 4;
    localparam int SMEAR_W       = 64;

    typedef enum logic [1:0] {
        RS_IDLE  = 2'd0,
        RS_CLEAR = 2'd1,
        RS_LOAD  = 2'd2,
        RS_SHIFT = 2'd3
    } rs_op_t;

    // Lowest set bit and every bit above it; zero mask stays zero.
    // mask | -mask keeps the lowest set bit and sets everything above it.
    function automatic logic [SMEAR_W-1:0] taint_smear_up(input logic [SMEAR_W-1:0] mask);
        return mask | (~mask + {{(SMEAR_W-1){1'b0}}, 1'b1});
    endfunction

endpackage

`default_nettype wire

// File: rtl/multiplier_datapath_taint_track_rs_taint_adder.sv
// ============================================================================
// Module : rs_taint_adder
// Brief  : (W+1)-bit running-sum add with carry-aware taint propagation.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rs_taint_adder
    import multiplier_datapath_taint_track_pkg::*;
#(
    parameter int W = WIDTH_DEFAULT
) (
    input  logic [W:0]   i_a,
    input  logic [W:0]   i_a_t,
    input  logic [W-1:0] i_b,
    input  logic [W-1:0] i_b_t,
    output logic [W:0]   o_sum,
    output logic [W:0]   o_sum_t
);

    logic [W:0]         w_mask;
    logic [SMEAR_W-1:0] w_smear_full;
    logic               w_unused_smear;

    assign o_sum  = i_a + {1'b0, i_b};
    assign w_mask = i_a_t | {1'b0, i_b_t};

    // A tainted input bit can disturb its own position and, via carries,
    // every position above it.
    assign w_smear_full   = taint_smear_up(SMEAR_W'(w_mask));
    assign o_sum_t        = w_smear_full[W:0];
    assign w_unused_smear = &{1'b0, w_smear_full[SMEAR_W-1:W+1]};

endmodule

`default_nettype wire

// File: rtl/multiplier_datapath_taint_track.sv
// ============================================================================
// Module : multiplier_datapath_taint_track
// Brief  : Shift-add multiplier datapath with per-bit taint shadow registers.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multiplier_datapath_taint_track
    import multiplier_datapath_taint_track_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplicand_t,
    input  logic [WIDTH-1:0]   multiplier,
    input  logic [WIDTH-1:0]   multiplier_t,
    input  logic               mdld,
    input  logic               mdld_t,
    input  logic               mrld,
    input  logic               mrld_t,
    input  logic               rsclear,
    input  logic               rsclear_t,
    input  logic               rsload,
    input  logic               rsload_t,
    input  logic               rsshr,
    input  logic               rsshr_t,
    output logic [WIDTH-1:0]   multiplierReg,
    output logic [WIDTH-1:0]   multiplierReg_t,
    output logic [2*WIDTH-1:0] product,
    output logic [2*WIDTH-1:0] product_t
);

    logic [WIDTH-1:0] r_md;
    logic [WIDTH-1:0] r_md_t;
    logic [WIDTH-1:0] r_mr;
    logic [WIDTH-1:0] r_mr_t;
    logic [2*WIDTH:0] r_rs;
    logic [2*WIDTH:0] r_rs_t;

    rs_op_t           w_op;
    logic             w_rs_ctl_taint;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_sum_t;

    // The control taint covers every strobe consulted in the priority chain
    // before the winning operation: any of them flipping could change rs.
    always_comb begin
        w_op           = RS_IDLE;
        w_rs_ctl_taint = rsclear_t | rsload_t | rsshr_t;
        if (rsclear) begin
            w_op           = RS_CLEAR;
            w_rs_ctl_taint = rsclear_t;
        end else if (rsload) begin
            w_op           = RS_LOAD;
            w_rs_ctl_taint = rsclear_t | rsload_t;
        end else if (rsshr) begin
            w_op           = RS_SHIFT;
        end
    end

    rs_taint_adder #(
        .W (WIDTH)
    ) u_rs_taint_adder (
        .i_a     (r_rs[2*WIDTH:WIDTH]),
        .i_a_t   (r_rs_t[2*WIDTH:WIDTH]),
        .i_b     (r_md),
        .i_b_t   (r_md_t),
        .o_sum   (w_sum),
        .o_sum_t (w_sum_t)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_md   <= '0;
            r_md_t <= '0;
            r_mr   <= '0;
            r_mr_t <= '0;
            r_rs   <= '0;
            r_rs_t <= '0;
        end else begin
            if (mdld) begin
                r_md   <= multiplicand;
                r_md_t <= multiplicand_t;
            end
            if (mdld_t) begin
                r_md_t <= '1;
            end

            if (mrld) begin
                r_mr   <= multiplier;
                r_mr_t <= multiplier_t;
            end
            if (mrld_t) begin
                r_mr_t <= '1;
            end

            case (w_op)
                RS_CLEAR: begin
                    r_rs   <= '0;
                    r_rs_t <= '0;
                end
                RS_LOAD: begin
                    r_rs[2*WIDTH:WIDTH]   <= w_sum;
                    r_rs_t[2*WIDTH:WIDTH] <= w_sum_t;
                end
                RS_SHIFT: begin
                    r_rs   <= r_rs >> 1;
                    r_rs_t <= r_rs_t >> 1;
                end
                default: begin
                end
            endcase
            if (w_rs_ctl_taint) begin
                r_rs_t <= '1;
            end
        end
    end

    assign multiplierReg   = r_mr;
    assign multiplierReg_t = r_mr_t;
    assign product         = r_rs[2*WIDTH-1:0];
    assign product_t       = r_rs_t[2*WIDTH-1:0];

endmodule

`default_nettype wire

// File: tb/tb_multiplier_datapath_taint_track.sv
// ============================================================================
// Module : tb_multiplier_datapath_taint_track
// Brief  : Scoreboard bench with directed multiply, taint and reset vectors.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multiplier_datapath_taint_track;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] multiplicand, multiplicand_t, multiplier, multiplier_t;
    logic       mdld, mdld_t, mrld, mrld_t;
    logic       rsclear, rsclear_t, rsload, rsload_t, rsshr, rsshr_t;
    logic [3:0] multiplierReg, multiplierReg_t;
    logic [7:0] product, product_t;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string      name;
        logic [7:0] p;
        logic [7:0] pt;
        logic [3:0] mr;
        logic [3:0] mrt;
    } exp_t;

    exp_t q[$];

    // strobe vector order: {mdld, mrld, rsclear, rsload, rsshr}
    localparam logic [4:0] C_N    = 5'b00000;
    localparam logic [4:0] C_INIT = 5'b11100;
    localparam logic [4:0] C_S    = 5'b00001;
    localparam logic [4:0] C_L    = 5'b00010;
    localparam logic [4:0] C_ALL  = 5'b00111;
    localparam logic [4:0] C_CLRT = 5'b00100;
    localparam logic [4:0] C_MRT  = 5'b01000;

    multiplier_datapath_taint_track #(.WIDTH(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .multiplicand    (multiplicand),
        .multiplicand_t  (multiplicand_t),
        .multiplier      (multiplier),
        .multiplier_t    (multiplier_t),
        .mdld            (mdld),
        .mdld_t          (mdld_t),
        .mrld            (mrld),
        .mrld_t          (mrld_t),
        .rsclear         (rsclear),
        .rsclear_t       (rsclear_t),
        .rsload          (rsload),
        .rsload_t        (rsload_t),
        .rsshr           (rsshr),
        .rsshr_t         (rsshr_t),
        .multiplierReg   (multiplierReg),
        .multiplierReg_t (multiplierReg_t),
        .product         (product),
        .product_t       (product_t)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input string fld, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got 0x%02h expected 0x%02h", nm, fld, act, exp);
        end
    endtask

    // Monitor: outputs are registered, so a pushed expectation is due at the
    // falling edge following the rising edge that produced it.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.name, "product",   product,                 e.p);
            chk(e.name, "product_t", product_t,               e.pt);
            chk(e.name, "mr",        {4'h0, multiplierReg},   {4'h0, e.mr});
            chk(e.name, "mr_t",      {4'h0, multiplierReg_t}, {4'h0, e.mrt});
        end
    end

    task automatic step(input logic [4:0] s, input logic [4:0] st, input bit do_chk,
                        input string nm, input logic [7:0] p, input logic [7:0] pt,
                        input logic [3:0] r, input logic [3:0] rt);
        exp_t e;
        {mdld, mrld, rsclear, rsload, rsshr}          = s;
        {mdld_t, mrld_t, rsclear_t, rsload_t, rsshr_t} = st;
        @(posedge clk);
        #1;
        {mdld, mrld, rsclear, rsload, rsshr}          = 5'b0;
        {mdld_t, mrld_t, rsclear_t, rsload_t, rsshr_t} = 5'b0;
        if (do_chk) begin
            e.name = nm; e.p = p; e.pt = pt; e.mr = r; e.mrt = rt;
            q.push_back(e);
        end
    endtask

    task automatic ops(input logic [4:0] s);
        step(s, C_N, 1'b0, "", 8'h00, 8'h00, 4'h0, 4'h0);
    endtask

    initial begin
        rst = 1'b0;
        multiplicand = 4'h0; multiplicand_t = 4'h0;
        multiplier   = 4'h0; multiplier_t   = 4'h0;
        {mdld, mrld, rsclear, rsload, rsshr}          = 5'b0;
        {mdld_t, mrld_t, rsclear_t, rsload_t, rsshr_t} = 5'b0;

        step(C_INIT, 5'b11111, 1'b1, "reset", 8'h00, 8'h00, 4'h0, 4'h0);
        rst = 1'b1;

        // 5 x 3
        multiplicand = 4'd5; multiplier = 4'd3;
        step(C_INIT, C_N, 1'b1, "m5x3_init", 8'h00, 8'h00, 4'h3, 4'h0);
        ops(C_S); ops(C_L); ops(C_S);
        step(C_L, C_N, 1'b1, "m5x3_ld2", 8'h78, 8'h00, 4'h3, 4'h0);
        ops(C_S); ops(C_N); ops(C_S); ops(C_N);
        step(C_S, C_N, 1'b1, "m5x3_final", 8'h0F, 8'h00, 4'h3, 4'h0);

        // 15 x 15, rs[8] set after the 4th load
        multiplicand = 4'hF; multiplier = 4'hF;
        step(C_INIT, C_N, 1'b1, "m15_init", 8'h00, 8'h00, 4'hF, 4'h0);
        ops(C_S); ops(C_L); ops(C_S); ops(C_L); ops(C_S); ops(C_L); ops(C_S);
        step(C_L, C_N, 1'b1, "m15_ld4", 8'hC2, 8'h00, 4'hF, 4'h0);
        step(C_S, C_N, 1'b1, "m15_final", 8'hE1, 8'h00, 4'hF, 4'h0);

        // data taint on multiplicand bit 2
        multiplicand = 4'd5; multiplicand_t = 4'b0100; multiplier = 4'd1;
        ops(C_INIT); ops(C_S);
        step(C_L, C_N, 1'b1, "dt_ld", 8'h50, 8'hC0, 4'h1, 4'h0);
        ops(C_S); ops(C_N); ops(C_S); ops(C_N); ops(C_S); ops(C_N);
        step(C_S, C_N, 1'b1, "dt_final", 8'h05, 8'h1C, 4'h1, 4'h0);

        // strobe taint with strobe value 0
        step(C_N, C_CLRT, 1'b1, "clr_taint", 8'h05, 8'hFF, 4'h1, 4'h0);
        step(C_N, C_MRT,  1'b1, "mrld_taint", 8'h05, 8'hFF, 4'h1, 4'hF);

        // rs priority: clear wins over load and shift
        multiplicand = 4'd5; multiplicand_t = 4'h0; multiplier = 4'd3;
        step(C_INIT, C_N, 1'b1, "pri_init", 8'h00, 8'h00, 4'h3, 4'h0);
        ops(C_S);
        step(C_L, C_N, 1'b1, "pri_ld", 8'h50, 8'h00, 4'h3, 4'h0);
        step(C_ALL, C_N, 1'b1, "pri_all", 8'h00, 8'h00, 4'h3, 4'h0);

        // reset mid-run overrides a simultaneous load
        multiplicand = 4'd5; multiplicand_t = 4'b0001; multiplier = 4'd3; multiplier_t = 4'b0010;
        step(C_INIT, C_N, 1'b1, "rst_init", 8'h00, 8'h00, 4'h3, 4'h2);
        ops(C_S); ops(C_L); ops(C_S);
        step(C_L, C_N, 1'b1, "rst_ld2", 8'h78, 8'hF8, 4'h3, 4'h2);
        rst = 1'b0;
        step(C_L, C_N, 1'b1, "rst_mid", 8'h00, 8'h00, 4'h0, 4'h0);
        rst = 1'b1;

        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
